// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: register offsets, STATUS bit layout and transmitter FSM encodings.
// Firmware headers and the memory controller address decode use these same values.
package uart_tx_pkg;

  localparam logic [2:0] UART_TX_DATA_OFFSET = 3'h0;
  localparam logic [2:0] UART_STATUS_OFFSET  = 3'h4;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_BUSY_BIT     = 2;
  localparam int STATUS_OVERFLOW_BIT = 3;
  localparam int STATUS_COUNT_LSB    = 4;
  localparam int STATUS_COUNT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] packStatus(input logic full, input logic empty,
                                             input logic busy, input logic overflow,
                                             input logic [STATUS_COUNT_W-1:0] count);
    logic [31:0] word;
    word = '0;
    word[STATUS_FULL_BIT]     = full;
    word[STATUS_EMPTY_BIT]    = empty;
    word[STATUS_BUSY_BIT]     = busy;
    word[STATUS_OVERFLOW_BIT] = overflow;
    word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

  assign dout  = mem_q[rdPtr_q];
  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: TX_DATA pushes into a byte FIFO, STATUS reports
// FIFO state, line activity and a sticky overflow flag that clears when STATUS is read.
module uart_tx_peripheral
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_1000,
  parameter int          CLOCKS_PER_BIT = 234,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] output_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int TIMER_W = $clog2(CLOCKS_PER_BIT);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CLOCKS_PER_BIT - 1);

  uart_state_e        state_q, state_d;
  logic [TIMER_W-1:0] bitTimer_q, bitTimer_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bitIndex_q, bitIndex_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        outputData_q, outputData_d;

  logic               fifoFull, fifoEmpty, fifoPop, fifoPush;
  logic [7:0]         fifoDout;
  logic [COUNT_W-1:0] fifoCount;
  logic               selected, dataWrite, statusRead, timerExpired;
  logic [2:0]         offset;
  logic               unusedBits;

  assign selected     = (address[31:3] == BASE_ADDRESS[31:3]);
  assign offset       = {address[2], 2'b00};
  assign dataWrite    = selected && mem_write && (offset == UART_TX_DATA_OFFSET);
  assign statusRead   = selected && mem_read && (offset == UART_STATUS_OFFSET);
  assign fifoPush     = dataWrite;
  assign tx_busy      = (state_q != ST_IDLE) || !fifoEmpty;
  assign timerExpired = (bitTimer_q == '0);
  assign unusedBits   = ^{input_data[31:8], address[1:0]};
  assign output_data  = outputData_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (input_data[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // A dropping write in the same cycle as a STATUS read wins, so the flag stays set.
  always_comb begin
    overflow_d   = (overflow_q && !statusRead) || (dataWrite && fifoFull && !fifoPop);
    outputData_d = '0;
    if (statusRead) begin
      outputData_d = packStatus(fifoFull, fifoEmpty, tx_busy, overflow_q,
                                STATUS_COUNT_W'(fifoCount));
    end
  end

  always_comb begin
    state_d    = state_q;
    bitTimer_d = bitTimer_q;
    shift_d    = shift_q;
    bitIndex_d = bitIndex_q;
    fifoPop    = 1'b0;
    tx         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop    = 1'b1;
          shift_d    = fifoDout;
          bitTimer_d = TIMER_RELOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (timerExpired) begin
          bitTimer_d = TIMER_RELOAD;
          bitIndex_d = '0;
          state_d    = ST_DATA;
        end else begin
          bitTimer_d = bitTimer_q - 1'b1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (timerExpired) begin
          bitTimer_d = TIMER_RELOAD;
          shift_d    = {1'b0, shift_q[7:1]};
          bitIndex_d = bitIndex_q + 1'b1;
          if (bitIndex_q == 3'd7) state_d = ST_STOP;
        end else begin
          bitTimer_d = bitTimer_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (timerExpired) begin
          bitTimer_d = TIMER_RELOAD;
          state_d    = ST_IDLE;
        end else begin
          bitTimer_d = bitTimer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bitTimer_q   <= '0;
      shift_q      <= '0;
      bitIndex_q   <= '0;
      overflow_q   <= 1'b0;
      outputData_q <= '0;
    end else begin
      state_q      <= state_d;
      bitTimer_q   <= bitTimer_d;
      shift_q      <= shift_d;
      bitIndex_q   <= bitIndex_d;
      overflow_q   <= overflow_d;
      outputData_q <= outputData_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Self-checking bench for uart_tx_peripheral: a frame-level reference model is compared
// against the DUT every cycle, with directed scenarios plus randomized bus traffic.
module tb_uart_tx_peripheral;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = BASE;
  logic [31:0] input_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] output_data;
  logic        tx;
  logic        tx_busy;

  int assertCount = 0;
  int failCount = 0;
  bit checkEnable = 1'b0;

  // Reference model: a queue of pending bytes plus the position inside the current frame.
  logic [7:0]  modelQueue[$];
  int          frameCycle = -1;
  logic [7:0]  frameByte = '0;
  bit          modelOverflow = 1'b0;
  logic [31:0] expOutputData = '0;

  logic        mSel, mWrData, mRdStatus, mCanPop, mDrop, mBusy;
  logic [31:0] mOffset, mStatus;
  int          mSize;

  uart_tx_peripheral #(
    .BASE_ADDRESS  (BASE),
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .input_data (input_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .output_data(output_data),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  always #5 clock = ~clock;

  function automatic logic frameLevel(input int cycle, input logic [7:0] b);
    int slot;
    slot = cycle / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic logic expTx();
    if (frameCycle < 0) return 1'b1;
    return frameLevel(frameCycle, frameByte);
  endfunction

  function automatic logic expBusy();
    return (frameCycle >= 0) || (modelQueue.size() > 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    mem_write  = wr;
    mem_read   = rd;
    address    = addr;
    input_data = data;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, BASE, 32'h0);
  endtask

  // Model update at each rising edge, using the bus values the DUT samples on that edge.
  always @(posedge clock) begin
    if (!reset) begin
      modelQueue.delete();
      frameCycle    = -1;
      modelOverflow = 1'b0;
      expOutputData = '0;
    end else begin
      mSel      = (address >> 3) == (BASE >> 3);
      mOffset   = (address & 32'hFFFF_FFFC) - BASE;
      mWrData   = mSel && mem_write && (mOffset == 32'd0);
      mRdStatus = mSel && mem_read && (mOffset == 32'd4);
      mSize     = modelQueue.size();
      mCanPop   = (frameCycle < 0) && (mSize > 0);
      mBusy     = expBusy();
      mStatus   = (32'(mSize) << 4) | (32'(modelOverflow) << 3) | (32'(mBusy) << 2)
                | (32'(mSize == 0) << 1) | 32'(mSize == DEPTH);
      expOutputData = mRdStatus ? mStatus : 32'h0;
      mDrop         = mWrData && (mSize == DEPTH) && !mCanPop;
      modelOverflow = (modelOverflow && !mRdStatus) || mDrop;
      if (frameCycle >= 0) begin
        frameCycle++;
        if (frameCycle == 10 * CPB) frameCycle = -1;
      end
      if (mCanPop) begin
        frameByte  = modelQueue.pop_front();
        frameCycle = 0;
      end
      if (mWrData && !mDrop) modelQueue.push_back(input_data[7:0]);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (checkEnable) begin
      checkOutput("model tx", {31'b0, tx}, {31'b0, expTx()});
      checkOutput("model tx_busy", {31'b0, tx_busy}, {31'b0, expBusy()});
      checkOutput("model output_data", output_data, expOutputData);
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    logic [0:9]  a5Pattern;
    logic [31:0] rndAddr;
    logic        rndWr, rndRd;
    int          pick;

    a5Pattern = 10'b0101001011;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    checkEnable = 1'b1;

    $display("[TB] reset and idle");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, BASE, 32'h0);
      checkOutput("idle tx", {31'b0, tx}, 32'h1);
      checkOutput("idle tx_busy", {31'b0, tx_busy}, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("reset status", output_data, 32'h0000_0002);

    $display("[TB] single byte A5");
    applyStimulus(1'b1, 1'b0, BASE, 32'hFFFF_FFA5);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    for (int i = 0; i < 10 * CPB; i++) begin
      applyStimulus(1'b0, 1'b0, BASE, 32'h0);
      checkOutput($sformatf("a5 frame slot %0d", i / CPB), {31'b0, tx}, {31'b0, a5Pattern[i / CPB]});
      checkOutput("a5 busy in frame", {31'b0, tx_busy}, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("a5 busy after stop", {31'b0, tx_busy}, 32'h0);

    $display("[TB] five back-to-back writes");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, BASE, 32'(8'h11 * (i + 1)));
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("burst status", output_data, 32'h0000_0045);
    idleCycles(5 * (10 * CPB + 1) + 10);
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("burst drained status", output_data, 32'h0000_0002);

    $display("[TB] overflow");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, BASE, 32'(8'hC0 + i));
    applyStimulus(1'b1, 1'b0, BASE, 32'h0000_003C);
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    checkOutput("overflow status", output_data, 32'h0000_004D);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("overflow cleared", output_data, 32'h0000_0045);
    idleCycles(5 * (10 * CPB + 1) + 10);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, BASE, 32'(8'h5A + i));
    idleCycles(16);
    @(negedge clock);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    checkOutput("reset tx", {31'b0, tx}, 32'h1);
    checkOutput("reset busy", {31'b0, tx_busy}, 32'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("post-reset status", output_data, 32'h0000_0002);
    idleCycles(60);

    $display("[TB] unselected and TX_DATA read");
    applyStimulus(1'b1, 1'b0, BASE + 32'd8, 32'h0000_0077);
    applyStimulus(1'b0, 1'b1, BASE + 32'd8, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("unselected read", output_data, 32'h0);
    checkOutput("unselected write busy", {31'b0, tx_busy}, 32'h0);
    applyStimulus(1'b1, 1'b0, BASE + 32'd4, 32'h0000_00FF);
    applyStimulus(1'b0, 1'b1, BASE, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("tx_data read", output_data, 32'h0);
    applyStimulus(1'b0, 1'b1, BASE + 32'd7, 32'h0);
    applyStimulus(1'b0, 1'b0, BASE, 32'h0);
    checkOutput("status after ignored writes", output_data, 32'h0000_0002);

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 5)      rndAddr = BASE;
      else if (pick <= 7) rndAddr = BASE + 32'd4;
      else if (pick == 8) rndAddr = BASE + 32'd8;
      else                rndAddr = BASE - 32'd4;
      rndAddr = rndAddr | 32'($urandom_range(0, 3));
      rndWr = ($urandom_range(0, 99) < 6);
      rndRd = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 999) == 0) begin
        @(negedge clock);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end else begin
        applyStimulus(rndWr, rndRd, rndAddr, $urandom);
      end
    end
    idleCycles(DEPTH * (10 * CPB + 1) + 60);

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
